// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Clock cycles from leaving IDLE to the end of the last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits,
                                               input int unsigned read_latency);
    return 1 + read_latency + clks_per_bit * (1 + data_width + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO-side handshake and serial-line signals of the transmitter.
interface fifo_serial_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  read_from_stack;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output read_from_stack, tx, busy, frame_done
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  read_from_stack, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period down-counter; strobes on the last clock of each serial bit.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end_c
);
  localparam int unsigned  CW     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at RELOAD while idle so the first bit after run rises is full length.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || bit_end_c) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign bit_end_c = run && (cnt == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from a FIFO and sends each as an LSB-first start/data/parity/stop frame.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_serial_tx_if.master bus
);
  localparam int unsigned   BW        = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned   WW        = $clog2(READ_LATENCY) + 1;
  localparam int unsigned   STOP_LEN  = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned   SW        = $clog2(STOP_LEN) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(READ_LATENCY - 1);
  localparam logic [SW-1:0] STOP_LOAD = SW'(STOP_LEN - 1);
  localparam logic          STOP_ONE  = (STOP_LEN == 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic [BW-1:0]         bit_idx;
  logic [WW-1:0]         wait_cnt;
  logic [SW-1:0]         stop_cnt;
  logic                  run_c;
  logic                  bit_end_c;

  assign run_c = (state == START) || (state == DATA) || (state == PARITY);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run_c),
    .bit_end_c (bit_end_c)
  );

  // Outputs are set on the edge entering the cycle they describe; frame_done is raised one
  // stop cycle early so it lands on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      shreg               <= '0;
      par_bit             <= 1'b0;
      bit_idx             <= '0;
      wait_cnt            <= '0;
      stop_cnt            <= '0;
      bus.read_from_stack <= 1'b0;
      bus.tx              <= 1'b1;
      bus.busy            <= 1'b0;
      bus.frame_done      <= 1'b0;
    end else begin
      bus.read_from_stack <= 1'b0;
      bus.frame_done      <= 1'b0;
      case (state)
        IDLE: begin
          bus.tx <= 1'b1;
          if (bus.enable && !bus.fifo_empty) begin
            state               <= REQ;
            bus.read_from_stack <= 1'b1;
            bus.busy            <= 1'b1;
          end
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            shreg   <= bus.fifo_data;
            par_bit <= (^bus.fifo_data) ^ PAR_MODE;
            state   <= START;
            bus.tx  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        START: begin
          if (bit_end_c) begin
            state   <= DATA;
            bus.tx  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (bit_idx != LAST_BIT) begin
              bus.tx  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + BW'(1);
            end else if (PARITY_EN != 0) begin
              state  <= PARITY;
              bus.tx <= par_bit;
            end else begin
              state          <= STOP;
              bus.tx         <= 1'b1;
              stop_cnt       <= STOP_LOAD;
              bus.frame_done <= STOP_ONE;
            end
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            state          <= STOP;
            bus.tx         <= 1'b1;
            stop_cnt       <= STOP_LOAD;
            bus.frame_done <= STOP_ONE;
          end
        end
        STOP: begin
          if (stop_cnt == '0) begin
            if (bus.enable && !bus.fifo_empty) begin
              state               <= REQ;
              bus.read_from_stack <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            stop_cnt       <= stop_cnt - SW'(1);
            bus.frame_done <= (stop_cnt == SW'(1));
          end
        end
        default: begin
          state    <= IDLE;
          bus.tx   <= 1'b1;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
